// File: rtl/cnn_maxpool_flatten.sv
// 2x2 / stride-2 max-pooling engine: reads Layer-0 banks, writes Layer-1 banks and,
// when CNN_POOL_FLATTEN_EN is defined, a channel-interleaved Flatten copy.
module cnn_maxpool_flatten #(
  parameter int IMG_W  = 64,
  parameter int NUM_CH = 2,
  parameter int DATA_W = 20,
  parameter int ADDR_W = 12,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              crd,
  output logic [ADDR_W-1:0] caddr_rd,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              cwr,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [DATA_W-1:0] cdata_wr,
  output logic [SEL_W-1:0]  csel
);

  localparam int HALF = IMG_W / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CW-1:0]     POS_LAST = CW'(HALF - 1);
  localparam logic [CHW-1:0]    CH_LAST  = CHW'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] ROW1     = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ROW2     = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] HALF_A   = ADDR_W'(HALF);
`ifdef CNN_POOL_FLATTEN_EN
  localparam logic [ADDR_W-1:0] NCH_A    = ADDR_W'(NUM_CH);
  localparam logic [SEL_W-1:0]  SEL_FL   = SEL_W'(1 + 2 * NUM_CH);
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_CAP,
    S_WR_L1,
`ifdef CNN_POOL_FLATTEN_EN
    S_WR_FL,
`endif
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CHW-1:0]    ch_q, ch_d;
  logic [CW-1:0]     r_q, r_d;
  logic [CW-1:0]     c_q, c_d;
  logic [DATA_W-1:0] max_q, max_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              crd_q, crd_d;
  logic              cwr_q, cwr_d;
  logic [SEL_W-1:0]  csel_q, csel_d;
  logic [ADDR_W-1:0] caddr_rd_q, caddr_rd_d;
  logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d;
  logic [DATA_W-1:0] cdata_wr_q, cdata_wr_d;

  logic              advance;
  logic              last_pix;
  logic [ADDR_W-1:0] base_d;
  logic [ADDR_W-1:0] pix_d;

  assign last_pix = (ch_q == CH_LAST) && (r_q == POS_LAST) && (c_q == POS_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    r_d     = r_q;
    c_d     = c_q;
    max_d   = max_q;
    advance = 1'b0;

    case (state_q)
      S_IDLE: if (start) state_d = S_RD0;
      S_RD0:  state_d = S_RD1;
      S_RD1: begin
        state_d = S_RD2;
        max_d   = cdata_rd;
      end
      S_RD2, S_RD3, S_CAP: begin
        state_d = (state_q == S_RD2) ? S_RD3 : (state_q == S_RD3) ? S_CAP : S_WR_L1;
        // Strictly greater: a tie keeps the word already held.
        if (cdata_rd > max_q) max_d = cdata_rd;
      end
`ifdef CNN_POOL_FLATTEN_EN
      S_WR_L1: state_d = S_WR_FL;
      S_WR_FL: advance = 1'b1;
`else
      S_WR_L1: advance = 1'b1;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      state_d = last_pix ? S_DONE : S_RD0;
      if (c_q == POS_LAST) begin
        c_d = '0;
        if (r_q == POS_LAST) begin
          r_d  = '0;
          ch_d = (ch_q == CH_LAST) ? '0 : ch_q + CHW'(1);
        end else begin
          r_d = r_q + CW'(1);
        end
      end else begin
        c_d = c_q + CW'(1);
      end
    end

    // Port values are derived from the state being entered so they can be registered.
    base_d = ROW2 * ADDR_W'(r_d) + (ADDR_W'(c_d) << 1);
    pix_d  = HALF_A * ADDR_W'(r_d) + ADDR_W'(c_d);

    crd_d      = 1'b0;
    cwr_d      = 1'b0;
    csel_d     = '0;
    caddr_rd_d = caddr_rd_q;
    caddr_wr_d = caddr_wr_q;
    cdata_wr_d = cdata_wr_q;

    case (state_d)
      S_RD0, S_RD1, S_RD2, S_RD3: begin
        crd_d  = 1'b1;
        csel_d = SEL_W'(1) + SEL_W'(ch_d);
        case (state_d)
          S_RD0:   caddr_rd_d = base_d;
          S_RD1:   caddr_rd_d = base_d + ADDR_W'(1);
          S_RD2:   caddr_rd_d = base_d + ROW1;
          default: caddr_rd_d = base_d + ROW1 + ADDR_W'(1);
        endcase
      end
      S_WR_L1: begin
        cwr_d      = 1'b1;
        csel_d     = SEL_W'(1 + NUM_CH) + SEL_W'(ch_d);
        caddr_wr_d = pix_d;
        cdata_wr_d = max_d;
      end
`ifdef CNN_POOL_FLATTEN_EN
      S_WR_FL: begin
        cwr_d      = 1'b1;
        csel_d     = SEL_FL;
        caddr_wr_d = pix_d * NCH_A + ADDR_W'(ch_d);
        cdata_wr_d = max_d;
      end
`endif
      default: ;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ch_q       <= '0;
      r_q        <= '0;
      c_q        <= '0;
      max_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      csel_q     <= '0;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      r_q        <= r_d;
      c_q        <= c_d;
      max_q      <= max_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      csel_q     <= csel_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign crd      = crd_q;
  assign cwr      = cwr_q;
  assign csel     = csel_q;
  assign caddr_rd = caddr_rd_q;
  assign caddr_wr = caddr_wr_q;
  assign cdata_wr = cdata_wr_q;

endmodule

// File: tb/tb_cnn_maxpool_flatten.sv
// Scoreboard bench for cnn_maxpool_flatten: memory model answers reads, expected
// writes are queued per pass, a monitor pops and compares every write.
module tb_cnn_maxpool_flatten;

  localparam int IMG_W  = 64;
  localparam int NUM_CH = 2;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 12;
  localparam int SEL_W  = 3;
  localparam int HALF   = IMG_W / 2;
  localparam int NPIX   = NUM_CH * HALF * HALF;
`ifdef CNN_POOL_FLATTEN_EN
  localparam int PIX_CYC = 7;
`else
  localparam int PIX_CYC = 6;
`endif
  localparam int PASS_CYC = NPIX * PIX_CYC + 1;

  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              busy, done, crd, cwr;
  logic [ADDR_W-1:0] caddr_rd, caddr_wr;
  logic [DATA_W-1:0] cdata_rd, cdata_wr;
  logic [SEL_W-1:0]  csel;

  logic [DATA_W-1:0] l0 [NUM_CH][IMG_W*IMG_W];
  logic [DATA_W-1:0] obs [2];
  wr_t               exp_q [$];
  int                n_vec  = 0;
  int                n_fail = 0;

  always #5 clk = ~clk;

  cnn_maxpool_flatten #(
    .IMG_W(IMG_W), .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd),
    .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .csel(csel)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: max of every 2x2 window, in channel/row/column order.
  task automatic push_pass();
    logic [DATA_W-1:0] m, v;
    for (int ch = 0; ch < NUM_CH; ch++)
      for (int r = 0; r < HALF; r++)
        for (int c = 0; c < HALF; c++) begin
          m = '0;
          for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++) begin
              v = l0[ch][(2*r+dy)*IMG_W + 2*c + dx];
              if (v > m) m = v;
            end
          exp_q.push_back({SEL_W'(1 + NUM_CH + ch), ADDR_W'(r*HALF + c), m});
`ifdef CNN_POOL_FLATTEN_EN
          exp_q.push_back({SEL_W'(1 + 2*NUM_CH), ADDR_W'((r*HALF + c)*NUM_CH + ch), m});
`endif
        end
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < NUM_CH; k++)
      for (int i = 0; i < IMG_W*IMG_W; i++) l0[k][i] = DATA_W'(k*100 + i);
    l0[0][0] = 7; l0[0][1] = 7; l0[0][IMG_W] = 3; l0[0][IMG_W+1] = 7;
    l0[0][2] = 0; l0[0][3] = 0; l0[0][IMG_W+2] = 0; l0[0][IMG_W+3] = 20'hFFFFF;
  endtask

  task automatic fill_random();
    for (int k = 0; k < NUM_CH; k++)
      for (int i = 0; i < IMG_W*IMG_W; i++)
        l0[k][i] = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
  endtask

  // Layer-0 memory: data for a read appears the cycle after crd.
  initial begin
    logic              rd_pend;
    logic [SEL_W-1:0]  rd_sel;
    logic [ADDR_W-1:0] rd_addr;
    cdata_rd = '0;
    forever begin
      @(negedge clk);
      rd_pend = crd;
      rd_sel  = csel;
      rd_addr = caddr_rd;
      @(posedge clk);
      #1;
      if (rd_pend && rd_sel >= 1 && int'(rd_sel) <= NUM_CH)
        cdata_rd = l0[int'(rd_sel) - 1][rd_addr];
      else
        cdata_rd = '0;
    end
  end

  // Monitor: port rules every cycle, scoreboard compare on every write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
`ifdef CNN_POOL_FLATTEN_EN
        check("port_rules", {crd && cwr, !crd && !cwr && csel != '0}, 0);
`else
        check("port_rules", {crd && cwr, !crd && !cwr && csel != '0,
                             csel == SEL_W'(1 + 2*NUM_CH)}, 0);
`endif
        if (cwr) begin
          if (csel == SEL_W'(1 + NUM_CH) && caddr_wr < 2) obs[caddr_wr[0]] = cdata_wr;
          if (exp_q.size() == 0) begin
            check("spurious_write", cwr, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("write", {csel, caddr_wr, cdata_wr}, e);
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts cycles from the first RD0 (first crd) up to and including done.
  task automatic wait_done(input string name);
    int  cyc;
    bit  seen, got;
    cyc  = 0;
    seen = 0;
    got  = 0;
    if (crd) begin
      seen = 1;
      cyc  = 1;
    end
    for (int i = 0; i < PASS_CYC + 50 && !got; i++) begin
      @(negedge clk);
      if (!seen && crd) seen = 1;
      if (seen) cyc++;
      if (done) got = 1;
    end
    check({name, "_done_seen"}, got, 1'b1);
    check({name, "_cycles"}, cyc, PASS_CYC);
    check({name, "_busy_at_done"}, busy, 1'b0);
  endtask

  initial begin
    int  wr_cnt, done_cnt;
    bit  found;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Ramp data plus directed windows (7,7,3,7) and (0,0,0,0xFFFFF).
    fill_ramp();
    push_pass();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ramp");
    done_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("ramp_single_done", done_cnt, 0);
    check("ramp_queue_drained", exp_q.size(), 0);
    check("window_tie", obs[0], 20'd7);
    check("window_unsigned", obs[1], 20'hFFFFF);

    // Reset during the second pixel's RD2.
    fill_random();
    push_pass();
    pulse_start();
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (crd && caddr_rd == ADDR_W'(IMG_W + 2)) found = 1;
      else @(negedge clk);
    end
    check("abort_rd2_found", found, 1'b1);
    reset = 1'b1;
    #1;
    check("abort_outputs_zero", {busy, done, crd, cwr, csel, caddr_rd, caddr_wr, cdata_wr}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (cwr || busy) wr_cnt++;
    end
    check("abort_quiet", wr_cnt, 0);

    // Same data again from a fresh start.
    push_pass();
    pulse_start();
    wait_done("rerun");
    repeat (2) @(negedge clk);
    check("rerun_queue_drained", exp_q.size(), 0);

    // Start held high for the whole pass.
    fill_random();
    push_pass();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_done("held");
    check("held_queue_drained", exp_q.size(), 0);
    @(negedge clk);
    check("held_idle_gap", {busy, crd}, 2'b00);
    @(negedge clk);
    check("held_restart", {busy, crd, caddr_rd}, {2'b11, ADDR_W'(0)});
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("final_idle", {busy, cwr, crd}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_maxpool_flatten.md
Name: cnn_maxpool_flatten

Overview:
- Parametrised 2x2/stride-2 max-pooling engine for the CNN accelerator datapath.
- Runs after the convolution stage has filled the Layer-0 result banks.
- For each of NUM_CH kernel channels, it reads the Layer-0 bank through the shared crd/caddr_rd/cdata_rd/csel memory port and writes pooled results to the matching Layer-1 bank.
- It can also write a channel-interleaved Flatten (Layer-2) copy.

Parameters:
- IMG_W, 64, Layer-0 map width = height; must be even, >=2.
- NUM_CH, 2, number of kernel channels; 1..3.
- DATA_W, 20, result word width.
- ADDR_W, 12, memory address width; must hold IMG_W*IMG_W-1.
- SEL_W, 3, csel width; must hold 2*NUM_CH+1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- start  in  1  begin pooling pass; sampled only in IDLE
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse when the pass completes
- crd  out  1  memory read enable
- caddr_rd  out  ADDR_W  read address
- cdata_rd  in  DATA_W  read data, valid the cycle after crd
- cwr  out  1  memory write enable
- caddr_wr  out  ADDR_W  write address
- cdata_wr  out  DATA_W  write data
- csel  out  SEL_W  bank select

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- Bank encoding:
  - 0 = none.
  - Layer-0 channel k = 1+k.
  - Layer-1 channel k = 1+NUM_CH+k.
  - Flatten = 1+2*NUM_CH.
  - With NUM_CH=2 this gives 001/010/011/100/101.
- Reset (any time, including mid-pass):
  - State goes to IDLE.
  - busy=0, done=0, crd=0, cwr=0, csel=0, caddr_rd=0, caddr_wr=0, cdata_wr=0.
  - Loop counters clear. No partial result is written after reset.
- Loop order: ch outer (0..NUM_CH-1), then row r, then column c, with r,c in 0..IMG_W/2-1.
- States: IDLE, RD0, RD1, RD2, RD3, CAP, WR_L1, WR_FL, DONE.
- IDLE:
  - start=1 moves to RD0 next cycle and sets busy=1.
  - start while busy is ignored.
- Read addresses, with P = 2r*IMG_W + 2c:
  - RD0..RD3 each assert crd=1, csel=L0(ch).
  - caddr_rd = P, P+1, P+IMG_W, P+IMG_W+1 in that order.
- Capture and max:
  - Data returns one cycle after each request, in RD1, RD2, RD3 and CAP.
  - A running max register loads the first word and then keeps the unsigned maximum.
  - Equal values keep the held value.
- WR_L1:
  - cwr=1, csel=L1(ch), caddr_wr = r*(IMG_W/2)+c, cdata_wr = max.
- WR_FL (FLATTEN_EN only):
  - cwr=1, csel=Flatten, caddr_wr = (r*(IMG_W/2)+c)*NUM_CH + ch, cdata_wr = max.
- Advance:
  - After the last write of a pixel, advance c, then r, then ch. Each counter wraps to 0 when the next one increments.
  - If the pixel was the final one (ch=NUM_CH-1, r=c=IMG_W/2-1), go to DONE; otherwise go to RD0.
- DONE:
  - done=1 and busy=0 for one cycle, then IDLE.
  - start is accepted again in the cycle after DONE.
- Port rules:
  - crd and cwr are never high together.
  - csel=0 whenever both are low.
  - Addresses and data outputs are registered.
- Cycle counts:
  - Per pixel: 7 cycles with flatten, 6 without.
  - Pass: NUM_CH*(IMG_W/2)^2 * (7 or 6) + 1 cycles from the first RD0 to DONE inclusive.

Optional Feature:
- Macro: CNN_POOL_FLATTEN_EN.
- Defined: the WR_FL state exists and a Flatten copy is written after every L1 write.
- Undefined:
  - WR_L1 goes straight to advance; 6 cycles per pixel.
  - The Flatten csel value is never driven.

Test Plan:
- IMG_W=4, NUM_CH=2, flatten on. L0K0 = 0..15 row-major, L0K1 = 100..115. Pulse start:
  - L1K0 receives 5, 7, 13, 15 at addresses 0..3.
  - L1K1 receives 105, 107, 113, 115.
  - Flatten receives 5 @0, 7 @2, 13 @4, 15 @6, 105 @1, 107 @3, 113 @5, 115 @7.
  - done pulses once, 57 cycles after the first RD0.
- Window 7,7,3,7, then window 0,0,0,0xFFFFF:
  - Results are 7 and 0xFFFFF (unsigned compare; the tie keeps the value).
- Assert reset during the 2nd pixel's RD2:
  - All outputs read 0 in the same cycle, before the next clock edge.
  - No further writes occur.
  - A fresh start reproduces the full expected output.
- Hold start=1 throughout a pass:
  - Exactly one pass runs.
  - A second pass begins only in the cycle after DONE.
- Flatten macro undefined, IMG_W=4, NUM_CH=1:
  - csel is never 3.
  - 4 writes are produced.
  - done comes 25 cycles after the first RD0.
- Default IMG_W=64, NUM_CH=2, random data:
  - Scoreboard checks all 2048 L1 words and 2048 Flatten words.
  - crd and cwr are never high together.
  - csel=0 whenever both are idle.
